// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential signed ALU: op codes, FSM states, counter sizing.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIN  = 2'b10
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Unsigned iterative core: shift-add multiply and (with ALU_SEQ_DIV_EN) restoring divide.
// res_hi/res_lo show the value after the current step, so the caller can capture the final step directly.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
`ifdef ALU_SEQ_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             last
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum;
`ifdef ALU_SEQ_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   shifted;
`endif

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    sum    = '0;
`ifdef ALU_SEQ_DIV_EN
    div_d   = div_q;
    shifted = '0;
`endif
    if (load) begin
      hi_d   = '0;
      lo_d   = a_mag;
      opnd_d = b_mag;
      cnt_d  = '0;
`ifdef ALU_SEQ_DIV_EN
      div_d  = is_div;
`endif
    end else if (step) begin
      cnt_d = cnt_q + CW'(1);
      // Multiplier bits retire from lo while the product grows into hi from the top.
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
      if (div_q) begin
        shifted = {hi_q, lo_q[WIDTH-1]};
        if (shifted >= {1'b0, opnd_q}) begin
          shifted = shifted - {1'b0, opnd_q};
          lo_d    = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          lo_d    = {lo_q[WIDTH-2:0], 1'b0};
        end
        hi_d = shifted[WIDTH-1:0];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
`ifdef ALU_SEQ_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

  assign res_hi = hi_d;
  assign res_lo = lo_d;
  assign last   = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle signed ALU with start/done handshake; add/sub in 1 cycle, mul/div in WIDTH+1.
// ALU_SEQ_DIV_EN builds the divider; without it Ctrl=11 finishes at once with Zero=1, Overflow=1.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [1:0]       Ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResH,
  output logic [WIDTH-1:0] ResL,
  output logic             Zero,
  output logic             Overflow,
  output logic             Cout
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_h_q, res_h_d, res_l_q, res_l_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, cout_q, cout_d;

  logic             accept, iter_op, sub, neg;
  logic [WIDTH-1:0] a_mag, b_mag, it_hi, it_lo;
  logic             it_load, it_step, it_last;
  logic [WIDTH:0]   a_ext, b_ext, sum_ext;
  logic [2*WIDTH-1:0] prod;
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH-1:0] quo, rem;
`endif

  always_comb begin
    sub     = (Ctrl == OP_SUB);
    a_mag   = A[WIDTH-1] ? -A : A;
    b_mag   = B[WIDTH-1] ? -B : B;
    a_ext   = {A[WIDTH-1], A};
    b_ext   = sub ? ~{B[WIDTH-1], B} : {B[WIDTH-1], B};
    sum_ext = a_ext + b_ext + {{WIDTH{1'b0}}, sub};
    iter_op = (Ctrl == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
    iter_op = iter_op || (Ctrl == OP_DIV);
`endif
    neg  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    prod = neg ? -{it_hi, it_lo} : {it_hi, it_lo};
`ifdef ALU_SEQ_DIV_EN
    quo = neg ? -it_lo : it_lo;
    rem = a_q[WIDTH-1] ? -it_hi : it_hi;
`endif
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_h_d = res_h_q;
    res_l_d = res_l_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    cout_d  = cout_q;
    it_load = 1'b0;
    it_step = 1'b0;
    accept  = Start && !busy_q;
    case (state_q)
      S_CALC: begin
        it_step = 1'b1;
        if (it_last) begin
          state_d = S_FIN;
          cout_d  = 1'b0;
          if (op_q == OP_MUL) begin
            res_h_d = prod[2*WIDTH-1:WIDTH];
            res_l_d = prod[WIDTH-1:0];
            zero_d  = (prod == '0);
            ovf_d   = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
`ifdef ALU_SEQ_DIV_EN
          end else if (b_q == '0) begin
            res_h_d = a_q;
            res_l_d = '1;
            zero_d  = 1'b0;
            ovf_d   = 1'b1;
          end else if (a_q == MOST_NEG && b_q == '1) begin
            res_h_d = '0;
            res_l_d = MOST_NEG;
            zero_d  = 1'b0;
            ovf_d   = 1'b1;
          end else begin
            res_h_d = rem;
            res_l_d = quo;
            zero_d  = (quo == '0);
            ovf_d   = 1'b0;
`else
          end else begin
            res_h_d = '0;
            res_l_d = '0;
            zero_d  = 1'b1;
            ovf_d   = 1'b1;
`endif
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          a_d  = A;
          b_d  = B;
          op_d = op_e'(Ctrl);
          if (iter_op) begin
            state_d = S_CALC;
            it_load = 1'b1;
          end else begin
            state_d = S_FIN;
            if (Ctrl == OP_DIV) begin
              res_h_d = '0;
              res_l_d = '0;
              zero_d  = 1'b1;
              ovf_d   = 1'b1;
              cout_d  = 1'b0;
            end else begin
              res_h_d = {{(WIDTH-1){sum_ext[WIDTH]}}, sum_ext[WIDTH]};
              res_l_d = sum_ext[WIDTH-1:0];
              zero_d  = (sum_ext == '0);
              ovf_d   = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
              // Carry into the sign-extension bit is the unsigned carry out of bit WIDTH-1.
              cout_d  = sum_ext[WIDTH] ^ a_ext[WIDTH] ^ b_ext[WIDTH];
            end
          end
        end
      end
    endcase
    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_h_q <= '0;
      res_l_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_h_q <= res_h_d;
      res_l_q <= res_l_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      cout_q  <= cout_d;
    end
  end

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (it_load),
    .step   (it_step),
`ifdef ALU_SEQ_DIV_EN
    .is_div (Ctrl == OP_DIV),
`endif
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .res_hi (it_hi),
    .res_lo (it_lo),
    .last   (it_last)
  );

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign ResH     = res_h_q;
  assign ResL     = res_l_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;
  assign Cout     = cout_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=4; division vectors apply when ALU_SEQ_DIV_EN is defined.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst, Start;
  logic [1:0] Ctrl;
  logic [3:0] A, B;
  logic       Busy, Done, Zero, Overflow, Cout;
  logic [3:0] ResH, ResL;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Ctrl(Ctrl), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .ResH(ResH), .ResL(ResL),
    .Zero(Zero), .Overflow(Overflow), .Cout(Cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Presents one op for a single edge, then scrambles the operands; returns in cycle 1.
  task automatic start_op(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b);
    Start = 1'b1; Ctrl = c; A = a; B = b;
    tick();
    Start = 1'b0; A = ~a; B = b + 4'd5; Ctrl = ~c;
  endtask

  task automatic wait_done(input string tag, input int exp_cycle);
    int c = 1;
    while (Done !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    check(tag, c, exp_cycle);
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; Ctrl = 2'b00; A = 4'h0; B = 4'h0;
    tick(); tick();
    check("reset_outputs", {Busy, Done, ResH, ResL, Zero, Overflow, Cout}, 0);
    rst = 1'b0;
    tick();
    check("idle_quiet", {Busy, Done}, 2'b00);

    // add: -3 + 7 = 4 with unsigned carry
    start_op(2'b00, 4'b1101, 4'b0111);
    check("add_done", {Busy, Done}, 2'b01);
    check("add_res", {ResH, ResL}, 8'h04);
    check("add_flags", {Zero, Overflow, Cout}, 3'b001);
    tick();
    check("add_pulse_hold", {Done, ResH, ResL}, 9'h004);

    // sub: 7 - (-8) overflows, borrow so Cout=0
    start_op(2'b01, 4'b0111, 4'b1000);
    check("sub_done", {Busy, Done}, 2'b01);
    check("sub_res", {ResH, ResL}, 8'h0F);
    check("sub_flags", {Zero, Overflow, Cout}, 3'b010);

    // mul: -3 * 7 = -21; Start in cycle 2 is ignored
    start_op(2'b10, 4'b1101, 4'b0111);
    for (int c = 1; c <= 4; c++) begin
      check("mul_busy", {Busy, Done}, 2'b10);
      if (c == 3) check("mul_hold_prev", ResL, 4'hF);
      if (c == 2) begin
        Start = 1'b1; Ctrl = 2'b00; A = 4'h1; B = 4'h1;
      end else begin
        Start = 1'b0;
      end
      tick();
    end
    check("mul_done", {Busy, Done}, 2'b01);
    check("mul_res", {ResH, ResL}, 8'hEB);
    check("mul_flags", {Zero, Overflow, Cout}, 3'b010);
    tick();
    check("mul_no_queue", {Busy, Done, ResH, ResL}, 10'h0EB);

`ifdef ALU_SEQ_DIV_EN
    start_op(2'b11, 4'b1001, 4'b0010);
    wait_done("div_latency", 5);
    check("div_neg7_by_2", {ResH, ResL, Zero, Overflow, Cout}, 11'b1111_1101_000);
    start_op(2'b11, 4'b0111, 4'b1110);
    wait_done("div_latency2", 5);
    check("div_7_by_neg2", {ResH, ResL, Zero, Overflow, Cout}, 11'b0001_1101_000);
    start_op(2'b11, 4'b1001, 4'b0000);
    wait_done("div0_latency", 5);
    check("div_by_zero", {ResH, ResL, Zero, Overflow, Cout}, 11'b1001_1111_010);
    start_op(2'b11, 4'b1000, 4'b1111);
    wait_done("divmin_latency", 5);
    check("div_min_by_m1", {ResH, ResL, Zero, Overflow, Cout}, 11'b0000_1000_010);
`else
    start_op(2'b11, 4'b0101, 4'b0011);
    check("nodiv_done", {Busy, Done}, 2'b01);
    check("nodiv_res", {ResH, ResL, Zero, Overflow, Cout}, 11'b0000_0000_110);
`endif

    // reset in cycle 2 of a mul aborts it
    start_op(2'b10, 4'b0011, 4'b0011);
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_clear", {Busy, Done, ResH, ResL, Zero, Overflow, Cout}, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("rst_no_done", {Busy, Done}, 2'b00);
      tick();
    end
    start_op(2'b00, 4'b0011, 4'b0010);
    check("post_rst_add", {Busy, Done, ResH, ResL, Zero, Overflow, Cout}, 13'b01_0000_0101_000);

    // reset wins over a simultaneous Start
    rst = 1'b1; Start = 1'b1; Ctrl = 2'b00; A = 4'h1; B = 4'h1;
    tick();
    rst = 1'b0; Start = 1'b0;
    check("rst_start_clear", {Busy, Done, ResH, ResL, Zero, Overflow, Cout}, 0);
    tick();
    check("rst_start_dropped", {Busy, Done, ResL}, 6'h00);

    // held Start: add, mul, add, mul -> Done at 1, 6, 7, 12
    Start = 1'b1; Ctrl = 2'b00; A = 4'b0010; B = 4'b0011;
    tick();
    for (int c = 1; c <= 12; c++) begin
      check("b2b_done", Done, (c == 1 || c == 6 || c == 7 || c == 12) ? 1 : 0);
      case (c)
        1: begin
          check("b2b_add1", {ResH, ResL, Zero, Overflow, Cout}, 11'b0000_0101_000);
          Ctrl = 2'b10; A = 4'b1110; B = 4'b0011;
        end
        2: begin
          Ctrl = 2'b00; A = 4'b0100; B = 4'b1100;
        end
        6: check("b2b_mul1", {ResH, ResL, Zero, Overflow, Cout}, 11'b1111_1010_000);
        7: begin
          check("b2b_add2", {ResH, ResL, Zero, Overflow, Cout}, 11'b0000_0000_101);
          Ctrl = 2'b10; A = 4'b0111; B = 4'b0111;
        end
        8: begin
          Start = 1'b0; A = 4'h0; B = 4'h0;
        end
        12: check("b2b_mul2", {ResH, ResL, Zero, Overflow, Cout}, 11'b0011_0001_010);
        default: ;
      endcase
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
